// File: rtl/tensor_core_job_sequencer.sv
// tensor_core_job_sequencer: streams 18 operand bytes into the register file, kicks the tensor core, drains 9 result pairs.
// Optional feature macro: TENSOR_JOB_SEQ_ABORT_EN adds abort_in, which returns any active job to IDLE.
module tensor_core_job_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic                         start_in,
`ifdef TENSOR_JOB_SEQ_ABORT_EN
  input  logic                         abort_in,
`endif
  output logic                         busy_out,
  output logic                         done_out,
  input  logic                         load_valid_in,
  output logic                         load_ready_out,
  input  logic [DATA_WIDTH-1:0]        load_data_in,
  output logic                         rf_quad_write_enable_out,
  output logic [2:0]                   rf_quad_write_register_address_out,
  output logic [3:0][DATA_WIDTH-1:0]   rf_quad_write_data_out,
  output logic                         rf_non_bulk_write_enable_out,
  output logic [4:0]                   rf_non_bulk_write_register_address_out,
  output logic [DATA_WIDTH-1:0]        rf_non_bulk_write_data_out,
  output logic [3:0]                   rf_dual_read_register_address_out,
  input  logic [1:0][DATA_WIDTH-1:0]   rf_dual_read_data_in,
  output logic                         compute_start_out,
  input  logic                         compute_done_in,
  output logic                         result_valid_out,
  input  logic                         result_ready_in,
  output logic [1:0][DATA_WIDTH-1:0]   result_data_out
);
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, KICK, WAIT, DRAIN, DONE} state_e;
  state_e                       state_q;
  logic [4:0]                   cnt_q;
  logic [3:0]                   idx_q;
  logic [2:0][DATA_WIDTH-1:0]   stage_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         start_q;
  logic                         quad_we_q;
  logic [2:0]                   quad_addr_q;
  logic [3:0][DATA_WIDTH-1:0]   quad_data_q;
  logic                         nb_we_q;
  logic [4:0]                   nb_addr_q;
  logic [DATA_WIDTH-1:0]        nb_data_q;
  logic                         abort;
  logic                         load_hs;
  logic                         result_hs;
`ifdef TENSOR_JOB_SEQ_ABORT_EN
  assign abort = abort_in && (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif
  // An abort silences every strobe and handshake in the very cycle it is raised.
  assign load_ready_out = (state_q == LOAD) && (cnt_q < 5'd18) && !abort;
  assign result_valid_out = (state_q == DRAIN) && !abort;
  assign load_hs = load_valid_in && load_ready_out;
  assign result_hs = result_valid_out && result_ready_in;
  assign busy_out = busy_q;
  assign done_out = done_q && !abort;
  assign compute_start_out = start_q && !abort;
  assign rf_quad_write_enable_out = quad_we_q && !abort;
  assign rf_quad_write_register_address_out = quad_addr_q;
  assign rf_quad_write_data_out = quad_data_q;
  assign rf_non_bulk_write_enable_out = nb_we_q && !abort;
  assign rf_non_bulk_write_register_address_out = nb_addr_q;
  assign rf_non_bulk_write_data_out = nb_data_q;
  assign rf_dual_read_register_address_out = idx_q;
  assign result_data_out = rf_dual_read_data_in;
  // Job FSM: packs operands into quad/single writes, pulses start, waits for done, walks the dual-read index.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      quad_we_q   <= 1'b0;
      quad_addr_q <= '0;
      quad_data_q <= '0;
      nb_we_q     <= 1'b0;
      nb_addr_q   <= '0;
      nb_data_q   <= '0;
    end else begin
      quad_we_q <= 1'b0;
      nb_we_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            idx_q <= '0;
            if (start_in) begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end
          end
          LOAD: if (load_hs) begin
            case (cnt_q[1:0])
              2'd0: stage_q[0] <= load_data_in;
              2'd1: stage_q[1] <= load_data_in;
              2'd2: stage_q[2] <= load_data_in;
              default: ;
            endcase
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q >= 5'd16) begin
              nb_we_q   <= 1'b1;
              nb_addr_q <= cnt_q;
              nb_data_q <= load_data_in;
            end else if (cnt_q[1:0] == 2'd3) begin
              quad_we_q   <= 1'b1;
              quad_addr_q <= {1'b0, cnt_q[3:2]};
              quad_data_q <= {load_data_in, stage_q};
            end
            if (cnt_q == 5'd17) state_q <= FLUSH;
          end
          FLUSH: begin
            state_q <= KICK;
            start_q <= 1'b1;
          end
          KICK: state_q <= WAIT;
          WAIT: if (compute_done_in) state_q <= DRAIN;
          DRAIN: if (result_hs) begin
            if (idx_q == 4'd8) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tensor_core_job_sequencer.sv
// tb_tensor_core_job_sequencer: randomized job traffic checked every cycle against an event-timeline model.
module tb_tensor_core_job_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort_i = 1'b0;
  logic lv = 1'b0;
  logic [7:0] ld = 8'h00;
  logic rr = 1'b0;
  logic cd = 1'b0;
  logic busy, done, lr, qwe, nwe, cs, rv;
  logic [2:0] qa;
  logic [3:0][7:0] qd;
  logic [4:0] na;
  logic [7:0] nd;
  logic [3:0] ra;
  logic [1:0][7:0] rdi, rdo;
  logic [7:0] mem [18];
  logic [7:0] job [18];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int job_id = 0, seen_id = 0, ls = 18;
  int gap_pct = 0, stall_pct = 0, tc = -1;
  bit cd_always = 0;
  logic lhs = 1'b0;
  // model state: an active job is described by the cycles at which its milestones happened
  bit m_act = 0;
  int t_acc = -1, t_last = -1, t_dn = -1, t_fin = -1, m_nb = 0, m_nr = 0;
  logic [7:0] mb [18];
  bit pq = 0, pn = 0, npq, npn, ab, e_ready, e_start, e_valid, e_done;
  logic [2:0] epqa;
  logic [3:0][7:0] epqd;
  logic [4:0] epna;
  logic [7:0] epnd;
  bit prev_stall = 0;
  logic [15:0] prev_rdo;
  int j;
  logic [63:0] wlog [$];
  logic [15:0] rlog [$];
  int rcyc [$];
  int n_done = 0, t_cs_seen = -1, t_done_seen = -1;

  tensor_core_job_sequencer #(.DATA_WIDTH(8)) dut (
    .clock_in(clk), .reset_n_in(rst_n), .start_in(start),
`ifdef TENSOR_JOB_SEQ_ABORT_EN
    .abort_in(abort_i),
`endif
    .busy_out(busy), .done_out(done),
    .load_valid_in(lv), .load_ready_out(lr), .load_data_in(ld),
    .rf_quad_write_enable_out(qwe), .rf_quad_write_register_address_out(qa), .rf_quad_write_data_out(qd),
    .rf_non_bulk_write_enable_out(nwe), .rf_non_bulk_write_register_address_out(na), .rf_non_bulk_write_data_out(nd),
    .rf_dual_read_register_address_out(ra), .rf_dual_read_data_in(rdi),
    .compute_start_out(cs), .compute_done_in(cd),
    .result_valid_out(rv), .result_ready_in(rr), .result_data_out(rdo)
  );

  initial forever #5 clk = ~clk;

  always_comb begin
    int a;
    a = int'(ra);
    rdi = '0;
    if (a < 9) rdi = {mem[2*a+1], mem[2*a]};
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_w(input int i);
    if (i < 4) return {25'd0, 2'b01, 5'(i), job[4*i+3], job[4*i+2], job[4*i+1], job[4*i]};
    return {25'd0, 2'b10, 5'(12 + i), 24'd0, job[12+i]};
  endfunction

  always @(posedge clk) lhs <= lv && lr;

  // Operand source, result sink and a tensor core that answers 5 cycles after start.
  always @(posedge clk) begin
    #1;
    if (job_id != seen_id) begin
      seen_id = job_id;
      ls = 0;
    end else if (lhs) ls++;
    lv = (ls < 18) && ($urandom_range(99) >= gap_pct);
    ld = (ls < 18) ? job[ls] : 8'h00;
    rr = $urandom_range(99) >= stall_pct;
    if (cs) tc = 5;
    else if (tc >= 0) tc--;
    cd = cd_always || (tc == 0);
  end

  // Compare process: expected outputs of this cycle follow from the job's milestone cycles.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ready", lr, 0);
      chk("rst_qwe", qwe, 0); chk("rst_qa", qa, 0); chk("rst_qd", qd, 0);
      chk("rst_nwe", nwe, 0); chk("rst_na", na, 0); chk("rst_nd", nd, 0);
      chk("rst_ra", ra, 0); chk("rst_start", cs, 0); chk("rst_valid", rv, 0);
      m_act = 0; pq = 0; pn = 0; prev_stall = 0;
    end else begin
      ab = abort_i && m_act;
      e_ready = m_act && m_nb < 18 && !ab;
      e_start = m_act && t_last >= 0 && cyc == t_last + 2 && !ab;
      e_valid = m_act && t_dn >= 0 && cyc > t_dn && m_nr < 9 && !ab;
      e_done = m_act && t_fin >= 0 && cyc == t_fin + 1 && !ab;
      chk("busy", busy, m_act);
      chk("load_ready", lr, e_ready);
      chk("compute_start", cs, e_start);
      chk("result_valid", rv, e_valid);
      chk("done", done, e_done);
      chk("quad_we", qwe, pq && !ab);
      chk("nb_we", nwe, pn && !ab);
      if (pq && !ab) begin
        chk("quad_addr", qa, epqa);
        chk("quad_data", qd, epqd);
      end
      if (pn && !ab) begin
        chk("nb_addr", na, epna);
        chk("nb_data", nd, epnd);
      end
      if (e_valid) begin
        chk("read_addr", ra, m_nr);
        chk("result_data", rdo, {mem[2*m_nr+1], mem[2*m_nr]});
        if (prev_stall) chk("result_stable", rdo, prev_rdo);
      end
      prev_stall = e_valid && !rr;
      prev_rdo = rdo;
      if (qwe) wlog.push_back({25'd0, 2'b01, 5'(qa), qd});
      if (nwe) wlog.push_back({25'd0, 2'b10, na, 24'd0, nd});
      if (rv && rr) begin
        rlog.push_back(rdo);
        rcyc.push_back(cyc);
      end
      if (done) begin
        n_done++;
        t_done_seen = cyc;
      end
      if (cs) t_cs_seen = cyc;
      npq = 0; npn = 0;
      if (ab) m_act = 0;
      else if (!m_act) begin
        if (start) begin
          m_act = 1; t_acc = cyc; m_nb = 0; m_nr = 0;
          t_last = -1; t_dn = -1; t_fin = -1;
        end
      end else begin
        if (e_ready && lv) begin
          j = m_nb;
          mb[j] = ld;
          m_nb++;
          if (j >= 16) begin
            npn = 1; epna = 5'(j); epnd = ld;
          end else if (j % 4 == 3) begin
            npq = 1; epqa = 3'(j / 4); epqd = {mb[j], mb[j-1], mb[j-2], mb[j-3]};
          end
          if (j == 17) t_last = cyc;
        end
        if (t_last >= 0 && cyc >= t_last + 3 && t_dn < 0 && cd) t_dn = cyc;
        if (e_valid && rr) begin
          m_nr++;
          if (m_nr == 9) t_fin = cyc;
        end
        if (t_fin >= 0 && cyc == t_fin + 1) m_act = 0;
      end
      pq = npq; pn = npn;
    end
  end

  task automatic run_job(input bit hold);
    int k;
    job_id++;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 4000) begin
      tick();
      k++;
    end
    chk("job_completes", done, 1);
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_writes(input int base);
    chk("write_count", wlog.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (base + i < wlog.size()) chk("write_seq", wlog[base+i], exp_w(i));
  endtask

  initial begin
    int wb, rb, dp, k;
    for (int i = 0; i < 18; i++) begin
      job[i] = 8'(i + 1);
      mem[i] = 8'(i);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    // stall-free job with bytes 1..18 and register file holding 0..17
    wb = wlog.size(); rb = rlog.size(); dp = n_done;
    run_job(0);
    chk("A_write_count", wlog.size() - wb, 6);
    for (int i = 0; i < 4; i++)
      if (wb + i < wlog.size())
        chk("A_quad", wlog[wb+i], {25'd0, 2'b01, 5'(i), 8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)});
    if (wb + 5 < wlog.size()) begin
      chk("A_nb16", wlog[wb+4], {25'd0, 2'b10, 5'd16, 24'd0, 8'd17});
      chk("A_nb17", wlog[wb+5], {25'd0, 2'b10, 5'd17, 24'd0, 8'd18});
    end
    chk("A_start_latency", t_cs_seen - t_acc, 20);
    chk("A_done_latency", t_done_seen - t_acc, 35);
    chk("A_done_pulses", n_done - dp, 1);
    chk("A_result_count", rlog.size() - rb, 9);
    for (int i = 0; i < 9; i++)
      if (rb + i < rlog.size()) begin
        chk("A_result", rlog[rb+i], {8'(2*i+1), 8'(2*i)});
        chk("A_result_cycle", rcyc[rb+i] - rcyc[rb], i);
      end
    // randomized jobs with load gaps, result stalls and extreme values
    gap_pct = 40; stall_pct = 40;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 18; i++) begin
        job[i] = 8'($urandom);
        mem[i] = 8'($urandom);
      end
      job[$urandom_range(17)] = 8'h80;
      job[$urandom_range(17)] = 8'h7f;
      mem[$urandom_range(17)] = 8'h80;
      wb = wlog.size(); dp = n_done;
      run_job(0);
      check_writes(wb);
      chk("R_done_pulses", n_done - dp, 1);
    end
    // start held high and done asserted all along: minimum-length job, no restart
    gap_pct = 0; stall_pct = 0; cd_always = 1;
    dp = n_done;
    run_job(1);
    cd_always = 0;
    chk("H_min_length", t_done_seen - t_acc, 31);
    repeat (4) tick();
    chk("H_done_pulses", n_done - dp, 1);
    chk("H_idle_after", busy, 0);
    // reset after 10 operand bytes, then a fresh job
    for (int i = 0; i < 18; i++) job[i] = 8'($urandom);
    job_id++;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (ls < 10 && k < 200) begin
      tick();
      k++;
    end
    chk("X_reached_10", ls, 10);
    rst_n = 1'b0;
    #1;
    chk("X_busy", busy, 0); chk("X_qwe", qwe, 0); chk("X_nwe", nwe, 0);
    chk("X_ready", lr, 0); chk("X_start", cs, 0); chk("X_valid", rv, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    wb = wlog.size();
    run_job(0);
    check_writes(wb);
`ifdef TENSOR_JOB_SEQ_ABORT_EN
    job_id++;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (cs !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("Ab_reach_kick", cs, 1);
    tick();
    dp = n_done;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("Ab_busy", busy, 0);
    chk("Ab_valid", rv, 0);
    repeat (10) tick();
    chk("Ab_no_done", n_done - dp, 0);
    chk("Ab_idle", busy, 0);
`endif
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
